// File: rtl/l2_mem_pkg.sv
// Shared types and sizing helpers for the L2 main-memory controller.
// The optional L2_MEM_STATS_EN build adds request counters; nothing here depends on it.
package l2_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    RESP = 2'd3
  } l2_state_e;

  function automatic int line_w(input int words);
    return WORD_W * words;
  endfunction

  function automatic int beat_w(input int words);
    return $clog2(words);
  endfunction

  // Byte-offset bits inside one line (word offset plus byte-in-word).
  function automatic int offset_w(input int words);
    return $clog2(words) + 2;
  endfunction

  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int BEAT_W             = beat_w(DEF_WORDS_PER_LINE);
  localparam int OFFSET_W           = offset_w(DEF_WORDS_PER_LINE);

endpackage

// File: rtl/l2_mem_ctrl_if.sv
// L2-side request/response bus of the memory controller, plus busy and FSM debug state.
// L2_MEM_STATS_EN adds the rd_cnt_o / wr_cnt_o counters to the bus.
interface l2_mem_ctrl_if #(
  parameter int ADDR_W         = 32,
  parameter int WORDS_PER_LINE = 4
) ();
  import l2_mem_pkg::*;

  localparam int LINE_W = line_w(WORDS_PER_LINE);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // the sender holds valid and payload stable until that edge, ready may change freely.
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [LINE_W-1:0] req_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [LINE_W-1:0] rsp_rdata_o;
  logic              busy_o;
  l2_state_e         state_dbg;
`ifdef L2_MEM_STATS_EN
  logic [31:0]       rd_cnt_o;
  logic [31:0]       wr_cnt_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, busy_o, state_dbg, rd_cnt_o, wr_cnt_o
  );
  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, busy_o, state_dbg, rd_cnt_o, wr_cnt_o
  );
`else
  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, busy_o, state_dbg
  );
  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, busy_o, state_dbg
  );
`endif

endinterface

// File: rtl/l2_mem_ctrl_ram.sv
// Single-port word RAM: synchronous write, combinational read, contents not reset.
module mem_word_ram
  import l2_mem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/l2_mem_ctrl.sv
// Line-granular main-memory controller behind the L2: fixed access latency, then one word per beat.
// Define L2_MEM_STATS_EN to add saturating read/write request counters.
module l2_mem_ctrl
  import l2_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_WORDS      = 4096,
  parameter int LAT            = 10
) (
  input logic         clk_i,
  input logic         rst_ni,
  l2_mem_ctrl_if.slave bus
);

  localparam int LINE_W = line_w(WORDS_PER_LINE);
  localparam int BEAT_W = beat_w(WORDS_PER_LINE);
  localparam int MEM_AW = $clog2(MEM_WORDS);
  localparam int IDX_W  = MEM_AW - BEAT_W;
  localparam int LAT_W  = (LAT > 1) ? $clog2(LAT) : 1;

  l2_state_e         state_q, state_d;
  logic              we_q;
  logic [IDX_W-1:0]  line_idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] rdata_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic [BEAT_W-1:0] beat_cnt_q;

  logic              accept;
  logic              lat_done;
  logic              last_beat;
  logic              ram_we;
  logic [MEM_AW-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;
  logic              unused_addr;

  assign accept    = (state_q == IDLE) && bus.req_valid_i;
  assign lat_done  = (lat_cnt_q == LAT_W'(LAT - 1));
  assign last_beat = (beat_cnt_q == BEAT_W'(WORDS_PER_LINE - 1));

  // Offset and upper address bits are ignored; addresses wrap modulo the RAM depth.
  assign unused_addr = ^bus.req_addr_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)          state_d = (LAT == 0) ? XFER : WAIT;
      WAIT:    if (lat_done)        state_d = XFER;
      XFER:    if (last_beat)       state_d = RESP;
      RESP:    if (bus.rsp_ready_i) state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      we_q       <= 1'b0;
      line_idx_q <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      lat_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          we_q       <= bus.req_we_i;
          line_idx_q <= bus.req_addr_i[MEM_AW+1 -: IDX_W];
          wdata_q    <= bus.req_wdata_i;
          rdata_q    <= '0;
          lat_cnt_q  <= '0;
          beat_cnt_q <= '0;
        end
        WAIT: lat_cnt_q <= lat_cnt_q + LAT_W'(1);
        XFER: begin
          if (!we_q) rdata_q[beat_cnt_q*WORD_W +: WORD_W] <= ram_rdata;
          beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Reset wins over a pending beat, so an interrupted write commits only earlier beats.
  assign ram_we    = (state_q == XFER) && we_q && rst_ni;
  assign ram_addr  = {line_idx_q, beat_cnt_q};
  assign ram_wdata = wdata_q[beat_cnt_q*WORD_W +: WORD_W];

  mem_word_ram #(
    .DEPTH (MEM_WORDS),
    .AW    (MEM_AW)
  ) u_ram (
    .clk   (clk_i),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.state_dbg   = state_q;

`ifdef L2_MEM_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (accept) begin
      if (!bus.req_we_i && rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (bus.req_we_i && wr_cnt_q != 32'hFFFF_FFFF)  wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign bus.rd_cnt_o = rd_cnt_q;
  assign bus.wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_l2_mem_ctrl.sv
// Directed bench for l2_mem_ctrl: a LAT=10 instance (table vectors + corner sequences) and a LAT=0 instance.
module tb_l2_mem_ctrl;
  import l2_mem_pkg::*;

  localparam int LW = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          req_valid [2];
  logic          req_we    [2];
  logic          rsp_ready [2];
  logic [31:0]   req_addr  [2];
  logic [LW-1:0] req_wdata [2];
  logic          req_ready_w [2];
  logic          rsp_valid_w [2];
  logic          busy_w      [2];
  logic [LW-1:0] rsp_rdata_w [2];

  l2_mem_ctrl_if #(.ADDR_W(32), .WORDS_PER_LINE(4)) bus0 ();
  l2_mem_ctrl_if #(.ADDR_W(32), .WORDS_PER_LINE(4)) bus1 ();

  assign bus0.req_valid_i = req_valid[0];
  assign bus0.req_we_i    = req_we[0];
  assign bus0.req_addr_i  = req_addr[0];
  assign bus0.req_wdata_i = req_wdata[0];
  assign bus0.rsp_ready_i = rsp_ready[0];
  assign req_ready_w[0]   = bus0.req_ready_o;
  assign rsp_valid_w[0]   = bus0.rsp_valid_o;
  assign busy_w[0]        = bus0.busy_o;
  assign rsp_rdata_w[0]   = bus0.rsp_rdata_o;

  assign bus1.req_valid_i = req_valid[1];
  assign bus1.req_we_i    = req_we[1];
  assign bus1.req_addr_i  = req_addr[1];
  assign bus1.req_wdata_i = req_wdata[1];
  assign bus1.rsp_ready_i = rsp_ready[1];
  assign req_ready_w[1]   = bus1.req_ready_o;
  assign rsp_valid_w[1]   = bus1.rsp_valid_o;
  assign busy_w[1]        = bus1.busy_o;
  assign rsp_rdata_w[1]   = bus1.rsp_rdata_o;

  l2_mem_ctrl #(.ADDR_W(32), .WORDS_PER_LINE(4), .MEM_WORDS(4096), .LAT(10)) dut0 (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus0.slave)
  );
  l2_mem_ctrl #(.ADDR_W(32), .WORDS_PER_LINE(4), .MEM_WORDS(4096), .LAT(0)) dut1 (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus1.slave)
  );

  int acc_cnt0 = 0;
  always @(posedge clk) if (req_valid[0] && req_ready_w[0]) acc_cnt0++;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [LW-1:0] exp_q [$];

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_req(input int s, input logic we, input logic [31:0] addr,
                        input logic [LW-1:0] wd, output bit ok);
    int n;
    n = 0;
    req_valid[s] = 1'b1; req_we[s] = we; req_addr[s] = addr; req_wdata[s] = wd;
    while (!req_ready_w[s] && n < 50) begin @(posedge clk); #1; n++; end
    ok = req_ready_w[s];
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d", s);
    end else begin
      @(posedge clk); #1;
    end
    req_valid[s] = 1'b0;
  endtask

  task automatic wait_rsp(input int s, output int lat, output bit ok);
    lat = 0;
    while (!rsp_valid_w[s] && lat < 100) begin @(posedge clk); #1; lat++; end
    ok = rsp_valid_w[s];
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rsp_timeout dut%0d", s);
    end
  endtask

  task automatic run_txn(input int s, input string name, input logic we, input logic [31:0] addr,
                         input logic [LW-1:0] wd, input logic [LW-1:0] exp_rd, input int exp_lat);
    bit ok;
    int lat;
    logic [LW-1:0] exp;
    rsp_ready[s] = 1'b1;
    do_req(s, we, addr, wd, ok);
    if (!ok) return;
    exp_q.push_back(exp_rd);
    wait_rsp(s, lat, ok);
    exp = exp_q.pop_front();
    if (!ok) return;
    check({name, "_lat"}, LW'(lat), LW'(exp_lat));
    check({name, "_rdata"}, rsp_rdata_w[s], exp);
    @(posedge clk); #1;
    check({name, "_ready_after"}, LW'(req_ready_w[s]), LW'(1));
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    string         name;
    logic          we;
    logic [31:0]   addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] exp_rdata;
    int            exp_lat;
  } vec_t;

  localparam logic [LW-1:0] L1 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  localparam logic [LW-1:0] L2 = {32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000};
  localparam logic [LW-1:0] L3 = {32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hCAFE_BABE, 32'h1234_5678};
  localparam logic [LW-1:0] L4 = {32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0001, 32'h7FFF_FFFE};
  localparam logic [LW-1:0] L5 = {32'h5555_0004, 32'h5555_0003, 32'h5555_0002, 32'h5555_0001};
  localparam logic [LW-1:0] LO = {32'h0D0D_0004, 32'h0D0D_0003, 32'h0D0D_0002, 32'h0D0D_0001};
  localparam logic [LW-1:0] LN = {32'h9E9E_0004, 32'h9E9E_0003, 32'h9E9E_0002, 32'h9E9E_0001};
  localparam logic [LW-1:0] L6 = {32'h6666_0004, 32'h6666_0003, 32'h6666_0002, 32'h6666_0001};
  localparam logic [LW-1:0] L7 = {32'h7777_0004, 32'h7777_0003, 32'h7777_0002, 32'h7777_0001};

  vec_t vecs [9];
  bit   ok;
  int   lat, e, acc_b, base, lat_a;
  bit   pr, seen_a;
  logic [LW-1:0] mixed;

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"wr_100",    1'b1, 32'h0000_0100, L1,  '0, 14};
    vecs[1] = '{"rd_104",    1'b0, 32'h0000_0104, '0,  L1, 14};
    vecs[2] = '{"wr_4000",   1'b1, 32'h0000_4000, L2,  '0, 14};
    vecs[3] = '{"rd_0_wrap", 1'b0, 32'h0000_0000, '0,  L2, 14};
    vecs[4] = '{"rd_10c",    1'b0, 32'h0000_010C, '0,  L1, 14};
    vecs[5] = '{"wr_fff0",   1'b1, 32'h0000_FFF0, L3,  '0, 14};
    vecs[6] = '{"rd_3ff0",   1'b0, 32'h0000_3FF0, '0,  L3, 14};
    vecs[7] = '{"wr_200",    1'b1, 32'h0000_0200, L4,  '0, 14};
    vecs[8] = '{"rd_208",    1'b0, 32'h0000_0208, '0,  L4, 14};

    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = '0; req_wdata[s] = '0;
      rsp_ready[s] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", LW'(req_ready_w[0]), LW'(1));
    check("rst_rsp_valid", LW'(rsp_valid_w[0]), LW'(0));
    check("rst_busy",      LW'(busy_w[0]),      LW'(0));
    check("rst_rdata",     rsp_rdata_w[0],      '0);
    check("rst_busy_lat0", LW'(busy_w[1]),      LW'(0));
    rst_n = 1'b1;

    // Table vectors on the LAT=10 instance.
    for (int i = 0; i < 9; i++)
      run_txn(0, vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_rdata, vecs[i].exp_lat);

    // Response back-pressure: hold rsp_ready low for 5 cycles in RESP.
    rsp_ready[0] = 1'b0;
    do_req(0, 1'b0, 32'h0000_0100, '0, ok);
    wait_rsp(0, lat, ok);
    check("hold_lat", LW'(lat), LW'(14));
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", LW'(rsp_valid_w[0]), LW'(1));
      check("hold_rdata", rsp_rdata_w[0], L1);
      check("hold_ready", LW'(req_ready_w[0]), LW'(0));
      @(posedge clk); #1;
    end
    check("hold_valid_end", LW'(rsp_valid_w[0]), LW'(1));
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("hold_done_valid", LW'(rsp_valid_w[0]), LW'(0));
    check("hold_done_ready", LW'(req_ready_w[0]), LW'(1));
    check("hold_done_busy",  LW'(busy_w[0]),      LW'(0));

    // Back-to-back: request valid held continuously across two transactions.
    base = acc_cnt0;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h0000_0300; req_wdata[0] = L5;
    @(posedge clk); #1;
    req_we[0] = 1'b0; req_wdata[0] = '0;
    e = 0; acc_b = -1; lat_a = -1; seen_a = 1'b0;
    pr = req_ready_w[0];
    for (int i = 0; i < 40 && acc_b < 0; i++) begin
      @(posedge clk); e++; #1;
      if (pr) begin
        acc_b = e;
        req_valid[0] = 1'b0;
      end else begin
        if (rsp_valid_w[0] && !seen_a) begin
          seen_a = 1'b1; lat_a = e;
          check("b2b_wr_ack_rdata", rsp_rdata_w[0], '0);
        end
        pr = req_ready_w[0];
      end
    end
    req_valid[0] = 1'b0;
    check("b2b_first_lat", LW'(lat_a), LW'(14));
    check("b2b_second_accept_edge", LW'(acc_b), LW'(16));
    wait_rsp(0, lat, ok);
    check("b2b_second_lat", LW'(lat), LW'(14));
    check("b2b_second_rdata", rsp_rdata_w[0], L5);
    repeat (10) @(posedge clk);
    #1;
    check("b2b_idle_after", LW'(busy_w[0]), LW'(0));
    check("b2b_accept_count", LW'(acc_cnt0 - base), LW'(2));

    // Reset in the middle of a write, after two beats have committed.
    run_txn(0, "old_wr_500", 1'b1, 32'h0000_0500, LO, '0, 14);
    do_req(0, 1'b1, 32'h0000_0500, LN, ok);
    repeat (12) @(posedge clk);
    #1;
    check("mid_in_xfer", LW'(bus0.state_dbg), LW'(XFER));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_ready", LW'(req_ready_w[0]), LW'(1));
    check("mid_rst_valid", LW'(rsp_valid_w[0]), LW'(0));
    check("mid_rst_busy",  LW'(busy_w[0]),      LW'(0));
    check("mid_rst_rdata", rsp_rdata_w[0],      '0);
    mixed = {LO[127:64], LN[63:0]};
    run_txn(0, "mid_rd_500", 1'b0, 32'h0000_0500, '0, mixed, 14);

    // Reset and request in the same cycle: request must not be taken.
    rst_n = 1'b0;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h0000_0100;
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid[0] = 1'b0;
    rst_n = 1'b1;
    check("rst_req_not_taken", LW'(busy_w[0]), LW'(0));

    // LAT=0 instance.
    run_txn(1, "l0_wr_40", 1'b1, 32'h0000_0040, L6, '0, 4);
    run_txn(1, "l0_rd_40", 1'b0, 32'h0000_0040, '0, L6, 4);
    run_txn(1, "l0_wr_80", 1'b1, 32'h0000_0080, L7, '0, 4);
    run_txn(1, "l0_rd_84", 1'b0, 32'h0000_0084, '0, L7, 4);
    run_txn(1, "l0_rd_44", 1'b0, 32'h0000_0044, '0, L6, 4);
`ifdef L2_MEM_STATS_EN
    check("stats_rd_cnt", LW'(bus1.rd_cnt_o), LW'(3));
    check("stats_wr_cnt", LW'(bus1.wr_cnt_o), LW'(2));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
